// File: rtl/adc_sample_averager.sv
// Per-channel ADC offset calibration followed by offset-corrected block averaging.
// Define ADC_AVERAGER_SATURATE_EN to clamp averages to the 16-bit signed range instead of wrapping.
module adc_sample_averager #(
    parameter int unsigned NumberOfChannels   = 3,
    parameter int unsigned OffsetSamplesLog2  = 4,
    parameter int unsigned AverageSamplesLog2 = 2
) (
    input  logic                          Clk_ik,
    input  logic                          n_Reset_i,
    input  logic [16*NumberOfChannels-1:0] Data_ib,
    input  logic                          DataUpdated_i,
    input  logic                          Recalibrate_i,
    output logic [16*NumberOfChannels-1:0] q_Average_ob,
    output logic                          q_AverageValid_o,
    output logic [16*NumberOfChannels-1:0] q_Offset_ob,
    output logic                          q_Calibrated_o
);

    localparam int unsigned CalAccWidth = 16 + OffsetSamplesLog2;
    localparam int unsigned RunAccWidth = 17 + AverageSamplesLog2;
    localparam logic [8:0] CalLast = 9'((1 << OffsetSamplesLog2) - 1);
    localparam logic [8:0] RunLast = 9'((1 << AverageSamplesLog2) - 1);

    typedef enum logic {StCal, StRun} state_t;

    state_t                        state;
    logic [8:0]                    sampleCount;
    logic [CalAccWidth-1:0]        calAcc [NumberOfChannels];
    logic signed [RunAccWidth-1:0] runAcc [NumberOfChannels];

    logic [CalAccWidth-1:0]        calSum     [NumberOfChannels];
    logic signed [16:0]            diff       [NumberOfChannels];
    logic signed [RunAccWidth-1:0] runSum     [NumberOfChannels];
    logic [15:0]                   avgReduced [NumberOfChannels];
`ifdef ADC_AVERAGER_SATURATE_EN
    localparam logic signed [RunAccWidth-1:0] MaxAvg = RunAccWidth'(32767);
    localparam logic signed [RunAccWidth-1:0] MinAvg = -(RunAccWidth'(32768));
    logic signed [RunAccWidth-1:0] avgFull [NumberOfChannels];
`endif

    always_comb begin
        for (int c = 0; c < NumberOfChannels; c++) begin
            calSum[c] = calAcc[c] + CalAccWidth'(Data_ib[16*c +: 16]);
            diff[c]   = $signed({1'b0, Data_ib[16*c +: 16]}) - $signed({1'b0, q_Offset_ob[16*c +: 16]});
            runSum[c] = runAcc[c] + RunAccWidth'(diff[c]);
`ifdef ADC_AVERAGER_SATURATE_EN
            avgFull[c] = runSum[c] >>> AverageSamplesLog2;
            if (avgFull[c] > MaxAvg) begin
                avgReduced[c] = 16'h7FFF;
            end else if (avgFull[c] < MinAvg) begin
                avgReduced[c] = 16'h8000;
            end else begin
                avgReduced[c] = avgFull[c][15:0];
            end
`else
            // Low 16 bits of the arithmetic shift; wraps when out of range.
            avgReduced[c] = runSum[c][AverageSamplesLog2 +: 16];
`endif
        end
    end

    always_ff @(posedge Clk_ik or negedge n_Reset_i) begin
        if (!n_Reset_i) begin
            state            <= StCal;
            sampleCount      <= '0;
            q_Average_ob     <= '0;
            q_AverageValid_o <= 1'b0;
            q_Offset_ob      <= '0;
            q_Calibrated_o   <= 1'b0;
            for (int c = 0; c < NumberOfChannels; c++) begin
                calAcc[c] <= '0;
                runAcc[c] <= '0;
            end
        end else begin
            q_AverageValid_o <= 1'b0;
            if (Recalibrate_i) begin
                // A strobe coinciding with the request is intentionally discarded.
                state          <= StCal;
                sampleCount    <= '0;
                q_Calibrated_o <= 1'b0;
                for (int c = 0; c < NumberOfChannels; c++) begin
                    calAcc[c] <= '0;
                    runAcc[c] <= '0;
                end
            end else if (DataUpdated_i) begin
                case (state)
                    StCal: begin
                        if (sampleCount == CalLast) begin
                            for (int c = 0; c < NumberOfChannels; c++) begin
                                q_Offset_ob[16*c +: 16] <= calSum[c][CalAccWidth-1 -: 16];
                                calAcc[c]               <= '0;
                            end
                            sampleCount    <= '0;
                            state          <= StRun;
                            q_Calibrated_o <= 1'b1;
                        end else begin
                            for (int c = 0; c < NumberOfChannels; c++) begin
                                calAcc[c] <= calSum[c];
                            end
                            sampleCount <= sampleCount + 9'd1;
                        end
                    end
                    StRun: begin
                        if (sampleCount == RunLast) begin
                            for (int c = 0; c < NumberOfChannels; c++) begin
                                q_Average_ob[16*c +: 16] <= avgReduced[c];
                                runAcc[c]                <= '0;
                            end
                            sampleCount      <= '0;
                            q_AverageValid_o <= 1'b1;
                        end else begin
                            for (int c = 0; c < NumberOfChannels; c++) begin
                                runAcc[c] <= runSum[c];
                            end
                            sampleCount <= sampleCount + 9'd1;
                        end
                    end
                    default: state <= StCal;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Randomised bench for adc_sample_averager against a queue-based behavioural model.
module tb_adc_sample_averager;

    localparam int N    = 3;
    localparam int OffL = 4;
    localparam int AvgL = 2;
    localparam int CalN = 1 << OffL;
    localparam int AvgN = 1 << AvgL;

    logic            Clk_ik = 1'b0;
    logic            n_Reset_i = 1'b0;
    logic [16*N-1:0] Data_ib = '0;
    logic            DataUpdated_i = 1'b0;
    logic            Recalibrate_i = 1'b0;
    logic [16*N-1:0] q_Average_ob;
    logic            q_AverageValid_o;
    logic [16*N-1:0] q_Offset_ob;
    logic            q_Calibrated_o;

    adc_sample_averager #(
        .NumberOfChannels  (N),
        .OffsetSamplesLog2 (OffL),
        .AverageSamplesLog2(AvgL)
    ) dut (
        .Clk_ik          (Clk_ik),
        .n_Reset_i       (n_Reset_i),
        .Data_ib         (Data_ib),
        .DataUpdated_i   (DataUpdated_i),
        .Recalibrate_i   (Recalibrate_i),
        .q_Average_ob    (q_Average_ob),
        .q_AverageValid_o(q_AverageValid_o),
        .q_Offset_ob     (q_Offset_ob),
        .q_Calibrated_o  (q_Calibrated_o)
    );

    always #5 Clk_ik = ~Clk_ik;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    // Behavioural model state: what the outputs must be after the latest edge.
    logic [16*N-1:0] calQ [$];
    logic [16*N-1:0] runQ [$];
    bit              mCal   = 1'b0;
    bit              mValid = 1'b0;
    logic [15:0]     mOffset [N] = '{default: '0};
    logic [15:0]     mAvg    [N] = '{default: '0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int floorDiv(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] reduce16(input int a);
`ifdef ADC_AVERAGER_SATURATE_EN
        if (a > 32767) return 16'h7FFF;
        if (a < -32768) return 16'h8000;
`endif
        return 16'(a);
    endfunction

    task automatic modelReset();
        calQ.delete();
        runQ.delete();
        mCal   = 1'b0;
        mValid = 1'b0;
        for (int c = 0; c < N; c++) begin
            mOffset[c] = '0;
            mAvg[c]    = '0;
        end
    endtask

    task automatic modelEdge(input logic [16*N-1:0] d, input logic du, input logic rc);
        mValid = 1'b0;
        if (rc) begin
            calQ.delete();
            runQ.delete();
            mCal = 1'b0;
        end else if (du) begin
            if (!mCal) begin
                calQ.push_back(d);
                if (calQ.size() == CalN) begin
                    for (int c = 0; c < N; c++) begin
                        int sum = 0;
                        foreach (calQ[i]) sum += int'(calQ[i][16*c +: 16]);
                        mOffset[c] = 16'(sum / CalN);
                    end
                    calQ.delete();
                    mCal = 1'b1;
                end
            end else begin
                runQ.push_back(d);
                if (runQ.size() == AvgN) begin
                    for (int c = 0; c < N; c++) begin
                        int sum = 0;
                        foreach (runQ[i]) sum += int'(runQ[i][16*c +: 16]) - int'(mOffset[c]);
                        mAvg[c] = reduce16(floorDiv(sum, AvgN));
                    end
                    runQ.delete();
                    mValid = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [16*N-1:0] d, input logic du, input logic rc);
        Data_ib       = d;
        DataUpdated_i = du;
        Recalibrate_i = rc;
        @(posedge Clk_ik);
        if (!n_Reset_i) modelReset();
        else modelEdge(d, du, rc);
        #1;
        DataUpdated_i = 1'b0;
        Recalibrate_i = 1'b0;
    endtask

    function automatic logic [16*N-1:0] pack3(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    // Called at posedge+1; drops reset between edges and checks the immediate clear.
    task automatic asyncReset();
        #2;
        n_Reset_i = 1'b0;
        modelReset();
        #1;
        check("async_rst_cal", 64'(q_Calibrated_o), 64'd0);
        check("async_rst_offset", 64'(q_Offset_ob), 64'd0);
        check("async_rst_avg", 64'(q_Average_ob), 64'd0);
        check("async_rst_valid", 64'(q_AverageValid_o), 64'd0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        n_Reset_i = 1'b1;
    endtask

    always @(negedge Clk_ik) begin
        if (cmpEn) begin
            check("valid", 64'(q_AverageValid_o), 64'(mValid));
            check("calibrated", 64'(q_Calibrated_o), 64'(mCal));
            for (int c = 0; c < N; c++) begin
                check($sformatf("offset_ch%0d", c), 64'(q_Offset_ob[16*c +: 16]), 64'(mOffset[c]));
                check($sformatf("avg_ch%0d", c), 64'(q_Average_ob[16*c +: 16]), 64'(mAvg[c]));
            end
        end
    end

    initial begin
        @(posedge Clk_ik);
        #1;
        cmpEn = 1'b1;
        step('0, 1'b1, 1'b0);
        check("reset_outputs", 64'({q_Calibrated_o, q_AverageValid_o, q_Offset_ob, q_Average_ob}), 64'd0);
        n_Reset_i = 1'b1;

        // Calibration ramp with idle gaps: ch0 1000..1030 step 2 -> 1015, ch2 -> 30007.
        for (int i = 0; i < CalN; i++) begin
            step(pack3(1000 + 2 * i, 2000, 30000 + i), 1'b1, 1'b0);
            if (i == CalN - 2) check("cal_not_done", 64'(q_Calibrated_o), 64'd0);
            if (i % 5 == 0) step('0, 1'b0, 1'b0);
        end
        check("cal_done", 64'(q_Calibrated_o), 64'd1);
        check("offset_ch0_lit", 64'(q_Offset_ob[15:0]), 64'd1015);
        check("offset_ch2_lit", 64'(q_Offset_ob[47:32]), 64'd30007);

        // Diffs -2, 0, 1, -1 -> sum -2 -> floor(-0.5) = -1.
        step(pack3(1013, 2000, 30007), 1'b1, 1'b0);
        step(pack3(1015, 2000, 30007), 1'b1, 1'b0);
        step(pack3(1016, 2000, 30007), 1'b1, 1'b0);
        check("no_early_valid", 64'(q_AverageValid_o), 64'd0);
        step(pack3(1014, 2004, 30007), 1'b1, 1'b0);
        check("avg_valid_lit", 64'(q_AverageValid_o), 64'd1);
        check("avg_ch0_lit", 64'(q_Average_ob[15:0]), 64'hFFFF);
        check("avg_ch1_lit", 64'(q_Average_ob[31:16]), 64'd1);
        step('0, 1'b0, 1'b0);
        check("valid_one_cycle", 64'(q_AverageValid_o), 64'd0);

        // Recalibrate together with a strobe: the strobe must not count.
        step(pack3(1, 1, 1), 1'b1, 1'b0);
        step(pack3(9, 9, 9), 1'b1, 1'b1);
        check("recal_cal_low", 64'(q_Calibrated_o), 64'd0);
        check("recal_keeps_offset", 64'(q_Offset_ob[15:0]), 64'd1015);
        for (int i = 0; i < CalN; i++) begin
            step(pack3(40000, 40000, 40000), 1'b1, 1'b0);
            if (i == CalN - 2) check("old_offset_visible", 64'(q_Offset_ob[15:0]), 64'd1015);
        end
        check("new_offset_lit", 64'(q_Offset_ob[15:0]), 64'd40000);

        // Four zeros against offset 40000: avg -40000.
        for (int i = 0; i < AvgN; i++) step('0, 1'b1, 1'b0);
`ifdef ADC_AVERAGER_SATURATE_EN
        check("range_lit", 64'(q_Average_ob[15:0]), 64'h8000);
`else
        check("range_lit", 64'(q_Average_ob[15:0]), 64'h63C0);
`endif

        // Reset mid-block, then the full calibration length is needed again.
        step(pack3(40001, 40001, 40001), 1'b1, 1'b0);
        asyncReset();
        for (int i = 0; i < CalN - 1; i++) step(pack3(7, 8, 9), 1'b1, 1'b0);
        check("post_rst_not_cal", 64'(q_Calibrated_o), 64'd0);
        step(pack3(7, 8, 9), 1'b1, 1'b0);
        check("post_rst_cal", 64'(q_Calibrated_o), 64'd1);

        // Randomised traffic with bursts, recalibrations and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            logic [16*N-1:0] d;
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < N; c++) begin
                if (wide) d[16*c +: 16] = 16'($urandom);
                else d[16*c +: 16] = 16'(32000 + $urandom_range(0, 1500));
            end
            if ($urandom_range(0, 999) == 0) begin
                asyncReset();
            end else begin
                step(d, ($urandom_range(0, 99) < 65), ($urandom_range(0, 299) == 0));
            end
        end

        step('0, 1'b0, 1'b0);
        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
